// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizing constants and decode helpers for the scoreboarded register file
package regfile_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;
  function automatic int nregs(input int addr_w);
    return 1 << addr_w;
  endfunction
  // Callers truncate the result to their register count; addresses up to 8 bits are supported.
  function automatic logic [255:0] onehot(input logic [7:0] addr, input logic en);
    return 256'(en) << addr;
  endfunction
endpackage

// File: rtl/regfile_sb_rdport.sv
// regfile_sb_rdport: one combinational read port with write bypass and busy masking
module regfile_sb_rdport #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int ZERO_REG = 0,
  parameter int BYPASS = 1
) (
  input  logic [2**ADDR_W-1:0][DATA_W-1:0] mem,
  input  logic [2**ADDR_W-1:0]             busy,
  input  logic                             wr_en0,
  input  logic [ADDR_W-1:0]                wr_addr0,
  input  logic [DATA_W-1:0]                wr_data0,
  input  logic                             wr_en1,
  input  logic [ADDR_W-1:0]                wr_addr1,
  input  logic [DATA_W-1:0]                wr_data1,
  input  logic [ADDR_W-1:0]                rd_addr,
  output logic [DATA_W-1:0]                rd_data,
  output logic                             rd_busy
);
  logic z, m0, m1;
  assign z = ZERO_REG != 0 && rd_addr == '0;
  assign m0 = BYPASS != 0 && wr_en0 && wr_addr0 == rd_addr;
  assign m1 = BYPASS != 0 && wr_en1 && wr_addr1 == rd_addr;
  assign rd_data = z ? '0 : m1 ? wr_data1 : m0 ? wr_data0 : mem[rd_addr];
  // A writeback forwarded this cycle resolves the hazard it would otherwise flag.
  assign rd_busy = busy[rd_addr] & ~(m0 | m1) & ~z;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: two-write/two-read register file with per-register busy scoreboard
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int ZERO_REG = 0,
  parameter int BYPASS = 1
) (
  input  logic                   clk,
  input  logic                   RESET,
  input  logic                   wr_en0,
  input  logic [ADDR_W-1:0]      wr_addr0,
  input  logic [DATA_W-1:0]      wr_data0,
  input  logic                   wr_en1,
  input  logic [ADDR_W-1:0]      wr_addr1,
  input  logic [DATA_W-1:0]      wr_data1,
  input  logic [ADDR_W-1:0]      rd_addrA,
  output logic [DATA_W-1:0]      rd_dataA,
  output logic                   rd_busyA,
  input  logic [ADDR_W-1:0]      rd_addrB,
  output logic [DATA_W-1:0]      rd_dataB,
  output logic                   rd_busyB,
  input  logic                   rsv_en,
  input  logic [ADDR_W-1:0]      rsv_addr,
  output logic                   rsv_ack,
  output logic [2**ADDR_W-1:0]   busy_vec
);
  localparam int NREGS = nregs(ADDR_W);
  logic [NREGS-1:0][DATA_W-1:0] mem;
  logic [NREGS-1:0] busy, w0, w1, rs, keep;
  logic rel;
  assign w0 = NREGS'(onehot(8'(wr_addr0), wr_en0));
  assign w1 = NREGS'(onehot(8'(wr_addr1), wr_en1));
  assign rs = NREGS'(onehot(8'(rsv_addr), rsv_en));
  assign keep = ZERO_REG != 0 ? ~NREGS'(1) : '1;
  // Re-reserving a register that is being written back this cycle is allowed.
  assign rel = |((w0 | w1) & rs);
  assign rsv_ack = rsv_en & (~busy[rsv_addr] | rel);
  assign busy_vec = busy;
  always_ff @(posedge clk) begin
    if (RESET) begin
      mem <= '0;
      busy <= '0;
    end else begin
      busy <= ((busy & ~(w0 | w1)) | (rs & {NREGS{rsv_ack}})) & keep;
      for (int i = 0; i < NREGS; i++)
        if (keep[i] && (w0[i] || w1[i])) mem[i] <= w1[i] ? wr_data1 : wr_data0;
    end
  end
  regfile_sb_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)) u_rd_a (
    .mem(mem), .busy(busy),
    .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
    .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
    .rd_addr(rd_addrA), .rd_data(rd_dataA), .rd_busy(rd_busyA)
  );
  regfile_sb_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)) u_rd_b (
    .mem(mem), .busy(busy),
    .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
    .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
    .rd_addr(rd_addrB), .rd_data(rd_dataB), .rd_busy(rd_busyB)
  );
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: scoreboard bench for regfile_sb; instance 0 default, 1 zero register, 2 no bypass
module tb_regfile_sb;
  logic clk = 0;
  logic RESET, wr_en0, wr_en1, rsv_en;
  logic [3:0] wr_addr0, wr_addr1, rd_addrA, rd_addrB, rsv_addr;
  logic [15:0] wr_data0, wr_data1;
  logic [15:0] rda[3], rdb[3], bv[3];
  logic ba[3], bb[3], ack[3];
  logic [31:0] exp_q[$];
  logic [31:0] e;
  int passed = 0, total = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g
    regfile_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(k == 1 ? 1 : 0), .BYPASS(k == 2 ? 0 : 1)) u (
      .clk(clk), .RESET(RESET),
      .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
      .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
      .rd_addrA(rd_addrA), .rd_dataA(rda[k]), .rd_busyA(ba[k]),
      .rd_addrB(rd_addrB), .rd_dataB(rdb[k]), .rd_busyB(bb[k]),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ack(ack[k]), .busy_vec(bv[k])
    );
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en0 = 0; wr_en1 = 0; rsv_en = 0;
  endtask

  task automatic test_reset();
    RESET = 1; wr_en0 = 1; wr_addr0 = 1; wr_data0 = 16'h1234; wr_en1 = 0; wr_addr1 = 0; wr_data1 = 0;
    rsv_en = 1; rsv_addr = 2; rd_addrA = 0; rd_addrB = 0;
    step();
    RESET = 0; wr_en0 = 0; rd_addrA = 1; rd_addrB = 2;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(1);
    #1;
    e = exp_q.pop_front(); total++; if (rda[0] !== e[15:0]) $display("FAIL reset_rdA got %h exp %h", rda[0], e[15:0]); else passed++;
    e = exp_q.pop_front(); total++; if (rdb[0] !== e[15:0]) $display("FAIL reset_rdB got %h exp %h", rdb[0], e[15:0]); else passed++;
    e = exp_q.pop_front(); total++; if (bb[0] !== e[0]) $display("FAIL reset_busyB got %b exp %b", bb[0], e[0]); else passed++;
    e = exp_q.pop_front(); total++; if (bv[0] !== e[15:0]) $display("FAIL reset_busy_vec got %h exp %h", bv[0], e[15:0]); else passed++;
    e = exp_q.pop_front(); total++; if (ack[0] !== e[0]) $display("FAIL reset_ack got %b exp %b", ack[0], e[0]); else passed++;
    idle();
  endtask

  task automatic test_write_read();
    wr_en0 = 1; wr_addr0 = 5; wr_data0 = 16'hBEEF; rd_addrA = 0;
    step();
    idle(); rd_addrA = 5;
    exp_q.push_back(32'hBEEF); exp_q.push_back(32'hBEEF); exp_q.push_back(0);
    #1;
    e = exp_q.pop_front(); total++; if (rda[0] !== e[15:0]) $display("FAIL wr_rd got %h exp %h", rda[0], e[15:0]); else passed++;
    e = exp_q.pop_front(); total++; if (rda[2] !== e[15:0]) $display("FAIL wr_rd_nobyp got %h exp %h", rda[2], e[15:0]); else passed++;
    e = exp_q.pop_front(); total++; if (bv[0] !== e[15:0]) $display("FAIL wr_nonbusy_vec got %h exp %h", bv[0], e[15:0]); else passed++;
  endtask

  task automatic test_priority_bypass();
    wr_en0 = 1; wr_addr0 = 3; wr_data0 = 16'h1111; wr_en1 = 1; wr_addr1 = 3; wr_data1 = 16'h2222; rd_addrA = 3;
    exp_q.push_back(32'h2222); exp_q.push_back(32'h0000);
    #1;
    e = exp_q.pop_front(); total++; if (rda[0] !== e[15:0]) $display("FAIL prio_bypass got %h exp %h", rda[0], e[15:0]); else passed++;
    e = exp_q.pop_front(); total++; if (rda[2] !== e[15:0]) $display("FAIL prio_nobyp_old got %h exp %h", rda[2], e[15:0]); else passed++;
    step();
    idle();
    exp_q.push_back(32'h2222); exp_q.push_back(32'h2222);
    #1;
    e = exp_q.pop_front(); total++; if (rda[0] !== e[15:0]) $display("FAIL prio_stored got %h exp %h", rda[0], e[15:0]); else passed++;
    e = exp_q.pop_front(); total++; if (rda[2] !== e[15:0]) $display("FAIL prio_stored_nobyp got %h exp %h", rda[2], e[15:0]); else passed++;
    wr_en0 = 1; wr_addr0 = 3; wr_data0 = 16'h3333; rd_addrB = 3;
    exp_q.push_back(32'h3333); exp_q.push_back(32'h2222);
    #1;
    e = exp_q.pop_front(); total++; if (rdb[0] !== e[15:0]) $display("FAIL byp_port0 got %h exp %h", rdb[0], e[15:0]); else passed++;
    e = exp_q.pop_front(); total++; if (rdb[2] !== e[15:0]) $display("FAIL nobyp_port0 got %h exp %h", rdb[2], e[15:0]); else passed++;
    step();
    idle();
  endtask

  task automatic test_raw();
    rsv_en = 1; rsv_addr = 7; rd_addrB = 7;
    exp_q.push_back(1); exp_q.push_back(0);
    #1;
    e = exp_q.pop_front(); total++; if (ack[0] !== e[0]) $display("FAIL raw_ack got %b exp %b", ack[0], e[0]); else passed++;
    e = exp_q.pop_front(); total++; if (bb[0] !== e[0]) $display("FAIL raw_busy_pre got %b exp %b", bb[0], e[0]); else passed++;
    step();
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(1);
    #1;
    e = exp_q.pop_front(); total++; if (ack[0] !== e[0]) $display("FAIL waw_ack got %b exp %b", ack[0], e[0]); else passed++;
    e = exp_q.pop_front(); total++; if (bv[0][7] !== e[0]) $display("FAIL raw_vec7 got %b exp %b", bv[0][7], e[0]); else passed++;
    e = exp_q.pop_front(); total++; if (bb[0] !== e[0]) $display("FAIL raw_busyB got %b exp %b", bb[0], e[0]); else passed++;
    e = exp_q.pop_front(); total++; if (bb[2] !== e[0]) $display("FAIL raw_busyB_nobyp got %b exp %b", bb[2], e[0]); else passed++;
    step();
    rsv_en = 0; wr_en0 = 1; wr_addr0 = 7; wr_data0 = 16'h00A5;
    exp_q.push_back(0); exp_q.push_back(32'h00A5); exp_q.push_back(1); exp_q.push_back(1);
    #1;
    e = exp_q.pop_front(); total++; if (bb[0] !== e[0]) $display("FAIL wb_busyB got %b exp %b", bb[0], e[0]); else passed++;
    e = exp_q.pop_front(); total++; if (rdb[0] !== e[15:0]) $display("FAIL wb_rdB got %h exp %h", rdb[0], e[15:0]); else passed++;
    e = exp_q.pop_front(); total++; if (bb[2] !== e[0]) $display("FAIL wb_busyB_nobyp got %b exp %b", bb[2], e[0]); else passed++;
    e = exp_q.pop_front(); total++; if (bv[0][7] !== e[0]) $display("FAIL wb_vec7_held got %b exp %b", bv[0][7], e[0]); else passed++;
    step();
    idle();
    exp_q.push_back(0); exp_q.push_back(32'h00A5);
    #1;
    e = exp_q.pop_front(); total++; if (bv[0][7] !== e[0]) $display("FAIL wb_vec7_clr got %b exp %b", bv[0][7], e[0]); else passed++;
    e = exp_q.pop_front(); total++; if (rdb[0] !== e[15:0]) $display("FAIL wb_stored got %h exp %h", rdb[0], e[15:0]); else passed++;
  endtask

  task automatic test_release_rereserve();
    rsv_en = 1; rsv_addr = 9;
    step();
    wr_en1 = 1; wr_addr1 = 9; wr_data1 = 16'h9999; rd_addrA = 9;
    exp_q.push_back(1); exp_q.push_back(1);
    #1;
    e = exp_q.pop_front(); total++; if (ack[0] !== e[0]) $display("FAIL reres_ack got %b exp %b", ack[0], e[0]); else passed++;
    e = exp_q.pop_front(); total++; if (ack[2] !== e[0]) $display("FAIL reres_ack_nobyp got %b exp %b", ack[2], e[0]); else passed++;
    step();
    idle();
    exp_q.push_back(1); exp_q.push_back(32'h9999); exp_q.push_back(1);
    #1;
    e = exp_q.pop_front(); total++; if (bv[0][9] !== e[0]) $display("FAIL reres_vec9 got %b exp %b", bv[0][9], e[0]); else passed++;
    e = exp_q.pop_front(); total++; if (rda[0] !== e[15:0]) $display("FAIL reres_data got %h exp %h", rda[0], e[15:0]); else passed++;
    e = exp_q.pop_front(); total++; if (ba[0] !== e[0]) $display("FAIL reres_busyA got %b exp %b", ba[0], e[0]); else passed++;
    wr_en0 = 1; wr_addr0 = 9; wr_data0 = 16'h9999;
    step();
    idle();
    exp_q.push_back(0);
    #1;
    e = exp_q.pop_front(); total++; if (bv[0][9] !== e[0]) $display("FAIL rel_vec9 got %b exp %b", bv[0][9], e[0]); else passed++;
  endtask

  task automatic test_zero_reg();
    wr_en0 = 1; wr_addr0 = 0; wr_data0 = 16'hFFFF; rsv_en = 1; rsv_addr = 0; rd_addrA = 0;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(32'hFFFF);
    #1;
    e = exp_q.pop_front(); total++; if (rda[1] !== e[15:0]) $display("FAIL zero_rd_same got %h exp %h", rda[1], e[15:0]); else passed++;
    e = exp_q.pop_front(); total++; if (ack[1] !== e[0]) $display("FAIL zero_ack got %b exp %b", ack[1], e[0]); else passed++;
    e = exp_q.pop_front(); total++; if (ba[1] !== e[0]) $display("FAIL zero_busy_same got %b exp %b", ba[1], e[0]); else passed++;
    e = exp_q.pop_front(); total++; if (rda[0] !== e[15:0]) $display("FAIL r0_bypass got %h exp %h", rda[0], e[15:0]); else passed++;
    step();
    idle();
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(32'hFFFF); exp_q.push_back(1);
    #1;
    e = exp_q.pop_front(); total++; if (rda[1] !== e[15:0]) $display("FAIL zero_rd_next got %h exp %h", rda[1], e[15:0]); else passed++;
    e = exp_q.pop_front(); total++; if (bv[1][0] !== e[0]) $display("FAIL zero_vec0 got %b exp %b", bv[1][0], e[0]); else passed++;
    e = exp_q.pop_front(); total++; if (ba[1] !== e[0]) $display("FAIL zero_busy_next got %b exp %b", ba[1], e[0]); else passed++;
    e = exp_q.pop_front(); total++; if (rda[0] !== e[15:0]) $display("FAIL r0_stored got %h exp %h", rda[0], e[15:0]); else passed++;
    e = exp_q.pop_front(); total++; if (bv[0][0] !== e[0]) $display("FAIL r0_vec0 got %b exp %b", bv[0][0], e[0]); else passed++;
  endtask

  task automatic test_reset_mid();
    rsv_en = 1; rsv_addr = 2;
    step();
    rsv_en = 0; wr_en0 = 1; wr_addr0 = 4; wr_data0 = 16'h4444; RESET = 1;
    step();
    RESET = 0; idle(); rd_addrA = 4; rd_addrB = 3;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    #1;
    e = exp_q.pop_front(); total++; if (rda[0] !== e[15:0]) $display("FAIL rstmid_r4 got %h exp %h", rda[0], e[15:0]); else passed++;
    e = exp_q.pop_front(); total++; if (rdb[0] !== e[15:0]) $display("FAIL rstmid_r3 got %h exp %h", rdb[0], e[15:0]); else passed++;
    e = exp_q.pop_front(); total++; if (bv[0] !== e[15:0]) $display("FAIL rstmid_vec got %h exp %h", bv[0], e[15:0]); else passed++;
    e = exp_q.pop_front(); total++; if (bv[1] !== e[15:0]) $display("FAIL rstmid_vec_zero got %h exp %h", bv[1], e[15:0]); else passed++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_priority_bypass();
    test_raw();
    test_release_rereserve();
    test_zero_reg();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
